// File: rtl/ibex_hpm_pkg.sv
// Shared types and constants for the hardware performance counter controller.
package ibex_hpm_pkg;

    typedef enum logic [2:0] {
        HpmCsrEvsel   = 3'd0,
        HpmCsrInhibit = 3'd1,
        HpmCsrCntLo   = 3'd2,
        HpmCsrCntHi   = 3'd3,
        HpmCsrOvfClr  = 3'd4,
        HpmCsrOvfIen  = 3'd5
    } hpm_csr_op_e;

    localparam int unsigned HpmMaxCounters = 29;
    localparam int unsigned HpmEvNever     = 0;

endpackage

// File: rtl/ibex_hpm_evsel.sv
// Per-counter event selector: holds the select register, muxes the event vector
// and registers the (inhibit-masked) event pulse.
module ibex_hpm_evsel
    import ibex_hpm_pkg::*;
#(
    parameter int unsigned NumEvents = 16,
    parameter int unsigned SelW      = $clog2(NumEvents)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumEvents-1:0] event_i,
    input  logic                 sel_we_i,
    input  logic [SelW-1:0]      sel_wdata_i,
    input  logic                 inhibit_i,
    output logic [SelW-1:0]      sel_o,
    output logic                 ev_o
);

    logic [SelW-1:0] sel_q, sel_d;
    logic            ev_q, ev_d;

    always_comb begin
        sel_d = sel_q;
        if (sel_we_i) begin
            sel_d = sel_wdata_i;
        end
        // Event 0 means "never"; selects past the vector width also never fire.
        ev_d = 1'b0;
        if (32'(sel_q) != HpmEvNever && 32'(sel_q) < NumEvents) begin
            ev_d = event_i[sel_q] & ~inhibit_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q <= '0;
            ev_q  <= 1'b0;
        end else begin
            sel_q <= sel_d;
            ev_q  <= ev_d;
        end
    end

    assign sel_o = sel_q;
    assign ev_o  = ev_q;

endmodule

// File: rtl/ibex_hpm_ctrl.sv
// Performance counter bank controller: event routing, inhibit, CSR strobes and
// overflow interrupt. Define IBEX_HPM_FREEZE_ON_OVF_EN to freeze all counters on
// an interrupt-enabled overflow.
module ibex_hpm_ctrl
    import ibex_hpm_pkg::*;
#(
    parameter int unsigned NumCounters  = 4,
    parameter int unsigned NumEvents    = 16,
    parameter int unsigned CounterWidth = 40
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumEvents-1:0]      event_i,
    input  logic                      csr_we_i,
    input  logic [2:0]                csr_op_i,
    input  logic [4:0]                csr_idx_i,
    input  logic [31:0]               csr_wdata_i,
    output logic [31:0]               csr_rdata_o,
    input  logic [NumCounters*64-1:0] cnt_val_i,
    output logic [NumCounters-1:0]    cnt_inc_o,
    output logic [NumCounters-1:0]    cnt_we_o,
    output logic [NumCounters-1:0]    cnt_hwe_o,
    output logic [31:0]               cnt_wdata_o,
    output logic                      irq_o
);

    localparam int unsigned SelW = $clog2(NumEvents);

    hpm_csr_op_e            csr_op;
    logic                   wr;
    logic [NumCounters-1:0] idx_dec;
    logic [NumCounters-1:0] ev_q;
    logic [NumCounters-1:0] ovf_hit;
    logic [SelW-1:0]        evsel_sel [NumCounters];

    logic [NumCounters-1:0] inhibit_q, inhibit_d;
    logic [NumCounters-1:0] ovf_q, ovf_d;
    logic [NumCounters-1:0] ien_q, ien_d;
    logic [NumCounters-1:0] ovf_clr;
    logic                   irq_q, irq_d;

    assign csr_op = hpm_csr_op_e'(csr_op_i);
    // Writes concurrent with reset are discarded.
    assign wr     = csr_we_i & ~rst_i;

    for (genvar k = 0; k < NumCounters; k++) begin : g_cnt
        assign idx_dec[k] = (32'(csr_idx_i) == k);
        assign ovf_hit[k] = cnt_inc_o[k] & (&cnt_val_i[64*k +: CounterWidth]);

        ibex_hpm_evsel #(
            .NumEvents (NumEvents),
            .SelW      (SelW)
        ) u_evsel (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .event_i     (event_i),
            .sel_we_i    (wr && csr_op == HpmCsrEvsel && idx_dec[k]),
            .sel_wdata_i (csr_wdata_i[SelW-1:0]),
            .inhibit_i   (inhibit_q[k]),
            .sel_o       (evsel_sel[k]),
            .ev_o        (ev_q[k])
        );
    end

    always_comb begin
        cnt_we_o  = '0;
        cnt_hwe_o = '0;
        if (wr && csr_op == HpmCsrCntLo) cnt_we_o = idx_dec;
        if (wr && csr_op == HpmCsrCntHi) cnt_hwe_o = idx_dec;
        // A counter write drops any increment due in the same cycle.
        cnt_inc_o = ev_q & ~(cnt_we_o | cnt_hwe_o) & {NumCounters{~rst_i}};
    end

    assign cnt_wdata_o = csr_wdata_i;

    always_comb begin
        inhibit_d = inhibit_q;
        ien_d     = ien_q;
        ovf_clr   = '0;
        if (wr) begin
            case (csr_op)
                HpmCsrInhibit: inhibit_d = csr_wdata_i[NumCounters-1:0];
                HpmCsrOvfIen:  ien_d     = csr_wdata_i[NumCounters-1:0];
                HpmCsrOvfClr:  ovf_clr   = csr_wdata_i[NumCounters-1:0];
                default: ;
            endcase
        end
        ovf_d = (ovf_q & ~ovf_clr) | ovf_hit;
`ifdef IBEX_HPM_FREEZE_ON_OVF_EN
        if (|(ovf_hit & ien_q)) begin
            inhibit_d = '1;
        end
`endif
        irq_d = |(ovf_q & ien_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inhibit_q <= '1;
            ovf_q     <= '0;
            ien_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            inhibit_q <= inhibit_d;
            ovf_q     <= ovf_d;
            ien_q     <= ien_d;
            irq_q     <= irq_d;
        end
    end

    assign irq_o = irq_q;

    always_comb begin
        csr_rdata_o = '0;
        case (csr_op)
            HpmCsrEvsel: begin
                for (int unsigned k = 0; k < NumCounters; k++) begin
                    if (idx_dec[k]) csr_rdata_o[SelW-1:0] = evsel_sel[k];
                end
            end
            HpmCsrCntLo: begin
                for (int unsigned k = 0; k < NumCounters; k++) begin
                    if (idx_dec[k]) csr_rdata_o = cnt_val_i[64*k +: 32];
                end
            end
            HpmCsrCntHi: begin
                for (int unsigned k = 0; k < NumCounters; k++) begin
                    if (idx_dec[k]) csr_rdata_o = cnt_val_i[64*k+32 +: 32];
                end
            end
            HpmCsrInhibit: csr_rdata_o[NumCounters-1:0] = inhibit_q;
            HpmCsrOvfClr:  csr_rdata_o[NumCounters-1:0] = ovf_q;
            HpmCsrOvfIen:  csr_rdata_o[NumCounters-1:0] = ien_q;
            default: ;
        endcase
    end

endmodule

// File: doc/ibex_hpm_ctrl.md
# ibex_hpm_ctrl

Controller for a bank of hardware performance counters built from the team's 64-bit counter primitive (width-configurable, load-low/load-high/increment inputs, 64-bit value out). It holds per-counter event selection, the inhibit mask, and overflow status with interrupt enables. It turns a single-port CSR write interface and a raw event vector into per-counter increment and write strobes, and raises an overflow interrupt. It sits between the CSR file and the counter instances.

## Interface
- `NumCounters`, default 4: counters managed, 1..29.
- `NumEvents`, default 16: width of the event vector, 2..64.
- `CounterWidth`, default 40: implemented counter bits, 1..64; sets the overflow point.
- `clk_i` in, 1: clock, the only clock.
- `rst_i` in, 1: reset, synchronous, active-high.
- `event_i` in, NumEvents: one-cycle event pulses; bit 0 is hardwired "never".
- `csr_we_i` in, 1: CSR write strobe.
- `csr_op_i` in, 3: `hpm_csr_op_e` (EVSEL, INHIBIT, CNT_LO, CNT_HI, OVF_CLR, OVF_IEN).
- `csr_idx_i` in, 5: counter index, for EVSEL/CNT_LO/CNT_HI.
- `csr_wdata_i` in, 32: write data.
- `csr_rdata_o` out, 32: combinational read of `csr_op_i`/`csr_idx_i`, with no side effects.
- `cnt_val_i` in, NumCounters*64: counter values, counter k at [64k+63:64k].
- `cnt_inc_o` out, NumCounters: per-counter increment.
- `cnt_we_o` out, NumCounters: low-word write.
- `cnt_hwe_o` out, NumCounters: high-word write.
- `cnt_wdata_o` out, 32: write data, equal to `csr_wdata_i`.
- `irq_o` out, 1: overflow interrupt, registered.

## Operation
- **Registers:**
  - `evsel_q[k]`: clog2(NumEvents) bits.
  - `inhibit_q`: NumCounters bits.
  - `ovf_q` and `ien_q`: NumCounters bits each.
- **Reset values:**
  - evsel 0, inhibit all-ones, ovf 0, ien 0.
  - Event pipeline 0, irq_o 0.
  - All strobes 0.
- **Event stage:**
  - `ev_q[k] = event_i[evsel_q[k]] & ~inhibit_q[k]` is registered every cycle.
  - `cnt_inc_o[k] = ev_q[k]`.
- **CSR writes:**
  - A write with `csr_idx_i >= NumCounters` is ignored, and no strobe fires.
  - EVSEL: `evsel_q[idx] <= wdata[clog2(NumEvents)-1:0]`.
  - INHIBIT: `inhibit_q <= wdata[NumCounters-1:0]`.
  - CNT_LO: `cnt_we_o[idx]` pulses in the same cycle as the write.
  - CNT_HI: `cnt_hwe_o[idx]` pulses in the same cycle as the write.
  - OVF_CLR: write-1-to-clear on `ovf_q`.
  - OVF_IEN: `ien_q <= wdata`.
- **Write versus increment:**
  - In any cycle where `cnt_we_o[k]|cnt_hwe_o[k]`, `cnt_inc_o[k]` is forced to 0. The pending event is dropped, not deferred.
- **Overflow:**
  - Condition: `cnt_inc_o[k]` and `cnt_val_i[k][CounterWidth-1:0]` all-ones.
  - On that condition, `ovf_q[k]` is set next cycle.
  - Set wins over a simultaneous OVF_CLR of the same bit.
- **Interrupt:** `irq_o <= |(ovf_q & ien_q)`, registered from the updated flops.
- **Read data:**
  - Zero-extended to 32 bits.
  - CNT_LO returns `cnt_val_i[k][31:0]`; CNT_HI returns `[63:32]`.
  - An out-of-range idx reads 0.

## Timing
- Event to `cnt_inc_o`: 1 cycle.
- Event to counter value: 2 cycles.
- INHIBIT/EVSEL write at cycle t: events sampled at t still use the old settings. Events at t+1 use the new ones.
- CNT_LO/HI write strobe: 0 cycles. The counter holds the new value at t+1.
- Overflow increment at t: `ovf_q` set at t+1, `irq_o` high at t+2 if enabled.
- Clearing the last enabled ovf bit at t drops `irq_o` at t+2.
- Reset asserted mid-operation:
  - All state returns to reset values at the next edge.
  - Strobes are 0 during reset.
  - A CSR write concurrent with reset is discarded.

## Configuration
- `IBEX_HPM_FREEZE_ON_OVF_EN`:
  - Defined: any overflow of a counter with `ien_q[k]=1` sets `inhibit_q` to all-ones in the same edge that sets `ovf_q[k]`, freezing all counters. This set wins over a simultaneous INHIBIT write. Software unfreezes by writing INHIBIT.
  - Undefined: overflow never touches `inhibit_q`.

## Structure
- Package `ibex_hpm_pkg`:
  - `hpm_csr_op_e` (3-bit enum, encodings 0..5 in the listed order).
  - Localparams `HpmMaxCounters=29`, `HpmEvNever=0`.
- Sub-module `ibex_hpm_evsel`:
  - One instance per counter, holding the evsel register, event mux and `ev_q` flop.
  - Generated NumCounters times.

## Test plan
- **Reset:** all strobes 0, irq_o 0, inhibit reads all-ones, evsel reads 0. An event_i pulse on bit 3 yields no `cnt_inc_o`.
- **Event routing:** EVSEL idx2=5, INHIBIT=0. Pulse event_i[5] at t -> `cnt_inc_o`=4'b0100 at t+1 only. Pulse event_i[0] -> no increment.
- **Write priority:** CNT_LO idx1 with data 0x1234 in the same cycle as a pending `ev_q[1]` -> `cnt_we_o[1]`=1, `cnt_inc_o[1]`=0, `cnt_wdata_o`=0x1234.
- **Overflow:** CounterWidth=40, counter0 value 0xFF_FFFF_FFFF, ien=1. Increment -> ovf_q[0]=1 next cycle, irq_o=1 the cycle after. OVF_CLR 0x1 -> irq_o=0 two cycles later. Overflow plus simultaneous clear -> bit stays set.
- **Freeze (macro defined):** the overflow above -> inhibit reads 0xF, and no further `cnt_inc_o` until INHIBIT=0 is written. With the macro undefined, inhibit stays 0.
- **Out of range:** write idx=7 with NumCounters=4 -> no strobes and no state change; read returns 0.
